// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-port arbiter for a shared LIFO stack; STACK_ARB_PRIO_EN selects fixed priority
module stack_arbiter #(
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          Clk,
  input  logic          RstN,
  input  logic          req0_valid,
  input  logic          req0_op,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_op,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp0_err,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic          rsp1_err,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q;
  logic          op_q;
  logic          port_q;
  logic [DW-1:0] data_q;
  logic [CW-1:0] count_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [DW-1:0] rsp_data_q;
  logic          stk_push_q;
  logic          stk_pop_q;

  logic          gnt_valid;
  logic          gnt_port;
  logic          gnt_op;
  logic [DW-1:0] gnt_data;
  logic          gnt_err;

`ifdef STACK_ARB_PRIO_EN
  // Fixed priority: port 0 wins whenever it is requesting
  always_comb begin
    gnt_port = ~req0_valid;
  end
`else
  logic last_q;

  // Round-robin: on contention grant the port that did not win last time
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_port = ~last_q;
    end else begin
      gnt_port = ~req0_valid;
    end
  end
`endif

  assign gnt_valid  = (state_q == IDLE) && (req0_valid || req1_valid);
  assign gnt_op     = gnt_port ? req1_op : req0_op;
  assign gnt_data   = gnt_port ? req1_data : req0_data;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  // Error requests are resolved from the shadow count, never the stack
  assign gnt_err    = gnt_op ? empty : full;

  assign req0_ready = gnt_valid && !gnt_port;
  assign req1_ready = gnt_valid && gnt_port;

  assign rsp0_valid = rsp_valid_q && !port_q;
  assign rsp1_valid = rsp_valid_q && port_q;
  assign rsp0_data  = rsp0_valid ? rsp_data_q : '0;
  assign rsp1_data  = rsp1_valid ? rsp_data_q : '0;
  assign rsp0_err   = rsp0_valid && rsp_err_q;
  assign rsp1_err   = rsp1_valid && rsp_err_q;

  assign stk_push   = stk_push_q;
  assign stk_pop    = stk_pop_q;
  assign stk_din    = stk_push_q ? data_q : '0;
  assign count      = count_q;

  // Request sequencer: accept, strobe the stack, collect data, respond
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      port_q      <= 1'b0;
      data_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
`ifndef STACK_ARB_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            op_q   <= gnt_op;
            port_q <= gnt_port;
            data_q <= gnt_data;
`ifndef STACK_ARB_PRIO_EN
            last_q <= gnt_port;
`endif
            if (gnt_err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              state_q     <= RESP;
            end else begin
              stk_push_q <= ~gnt_op;
              stk_pop_q  <= gnt_op;
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (op_q) begin
            count_q <= count_q - 1'b1;
            state_q <= WAIT;
          end else begin
            count_q     <= count_q + 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            state_q     <= RESP;
          end
        end
        WAIT: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= stk_dout;
          state_q     <= RESP;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
